prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter N, default 2, program address width; program depth is 2^N words of 8 bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_en  input  1  level request to load a new program; low aborts a load in progress.
REQ-005 SHALL have port ser_in  input  1  serial program bit, MSB of each word first.
REQ-006 SHALL have port ser_valid  input  1  ser_in is sampled only on cycles where this is high.
REQ-007 SHALL have port addr  input  N  instruction read address from the program counter.
REQ-008 SHALL have port instruction  output  8  program word at addr.
REQ-009 SHALL have port cpu_hold  output  1  high while the core must be held in reset.
REQ-010 SHALL have port busy  output  1  high while in state SHIFT.
REQ-011 SHALL have port done  output  1  high while in state RUN.

Function
REQ-012 SHALL implement the registered states IDLE, SHIFT and RUN.
REQ-013 In IDLE, load_en high SHALL move to SHIFT on the next edge and clear the bit count (3 bits), write pointer (N bits) and shift register (8 bits).
REQ-014 In SHIFT, each edge with ser_valid high SHALL shift ser_in into the LSB of the shift register (shift left) and increment the bit count.
REQ-015 In SHIFT, cycles with ser_valid low SHALL leave all state unchanged; gaps of any length are legal.
REQ-016 On the edge that accepts the 8th bit, SHALL write {shift[6:0], ser_in} to mem[wptr], increment wptr, and wrap the bit count to 0.
REQ-017 When the accepted word is written at wptr = 2^N-1, SHALL move to RUN on that same edge, with wptr wrapping to 0.
REQ-018 In SHIFT, load_en low SHALL override ser_valid and move to IDLE on the next edge: the partial word is discarded and words already written are retained.
REQ-019 In RUN, load_en high SHALL move to SHIFT on the next edge with counters cleared, as in REQ-013; memory is overwritten word by word as new words complete.
REQ-020 In RUN, load_en low SHALL hold RUN indefinitely.
REQ-021 In IDLE, load_en low SHALL hold IDLE.
REQ-022 instruction SHALL be combinational: mem[addr] when state is RUN, otherwise 8'h00.
REQ-023 cpu_hold SHALL be high in IDLE and SHIFT and low only in RUN.
REQ-024 All outputs SHALL be decoded from registered state, with no combinational path from ser_in or ser_valid to any output.
REQ-025 ser_in and ser_valid SHALL be ignored outside SHIFT.

Reset
REQ-026 rst high SHALL immediately force state IDLE, clear the bit count, wptr and shift register, and clear every memory word to 8'h00, independent of clk.
REQ-027 While rst is high, outputs SHALL be instruction=8'h00, cpu_hold=1, busy=0 and done=0.
REQ-028 rst asserted mid-SHIFT or in RUN SHALL discard all loaded content; a new load requires load_en after rst is released.
REQ-029 Release of rst SHALL take effect at the first rising clk edge after deassertion; no transition occurs on the release itself.

Verification
REQ-030 Full load: with N=2, load_en=1, stream 0x12, 0x34, 0x56, 0x78 with ser_valid=1 continuously -> done=1 and cpu_hold=0 after edge 33 (1 IDLE->SHIFT edge plus 32 bits); addr 0..3 reads 0x12, 0x34, 0x56, 0x78.
REQ-031 Gapped stream: same data with ser_valid low on every other cycle -> identical memory contents; busy stays high throughout; done=1 only after the 32nd accepted bit.
REQ-032 Abort: drop load_en after 13 bits (word 0 = 0xA5, plus 5 bits of word 1) -> IDLE, cpu_hold=1, instruction=0x00 for any addr; a following full load of 0x01, 0x02, 0x03, 0x04 reads back exactly those values.
REQ-033 Reload from RUN: after a full load, assert load_en and stream 0xFF x4 -> done drops on the next edge, busy rises, and final contents are all 0xFF.
REQ-034 Async reset: pulse rst between clock edges during the 20th bit of a load -> outputs go to reset values immediately; after release, even a complete load is required for done=1, and unloaded words read 0x00.
REQ-035 Ignore outside SHIFT: toggle ser_in and ser_valid randomly in IDLE and RUN -> memory, counters and outputs are unchanged.

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: shifts a program into a small instruction memory
// MSB-first, holds the core in reset while loading, and then releases it.
module prog_loader #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic         ser_in,
    input  logic         ser_valid,
    input  logic [N-1:0] addr,
    output logic [7:0]   instruction,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done
);

    localparam int unsigned Depth = 2 ** N;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StRun
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    logic [N-1:0] wptr_q, wptr_d;
    logic [7:0]   shift_q, shift_d;
    logic         we;
    logic [7:0]   wdata;
    logic [7:0]   mem_q [Depth];

    // Next-state logic: bit shifting, word completion and state transitions
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        wptr_d   = wptr_q;
        shift_d  = shift_q;
        we       = 1'b0;
        wdata    = {shift_q[6:0], ser_in};

        unique case (state_q)
            StIdle, StRun: begin
                if (load_en) begin
                    state_d  = StShift;
                    bitcnt_d = '0;
                    wptr_d   = '0;
                    shift_d  = '0;
                end
            end
            StShift: begin
                // load_en low wins over a valid bit: partial word is dropped
                if (!load_en) begin
                    state_d = StIdle;
                end else if (ser_valid) begin
                    shift_d  = wdata;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + N'(1);
                        if (wptr_q == {N{1'b1}}) begin
                            state_d = StRun;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            wptr_q   <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            wptr_q   <= wptr_d;
            shift_q  <= shift_d;
        end
    end

    // Program memory; reset wipes every word so stale code never runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: 8'h00};
        end else if (we) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        busy        = (state_q == StShift);
        done        = (state_q == StRun);
        cpu_hold    = (state_q != StRun);
        instruction = (state_q == StRun) ? mem_q[addr] : 8'h00;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of full loads plus hand-written
// abort, async-reset and ignore-outside-load sequences, with a readback
// scoreboard queue.
module tb_prog_loader;

    localparam int N     = 2;
    localparam int Depth = 4;

    typedef logic [7:0] word_arr_t [Depth];

    typedef struct {
        string     name;
        word_arr_t w;
        bit        gapped;
        logic      exp_done;
        logic      exp_hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_en = 1'b0;
    logic         ser_in = 1'b0;
    logic         ser_valid = 1'b0;
    logic [N-1:0] addr = '0;
    logic [7:0]   instruction;
    logic         cpu_hold;
    logic         busy;
    logic         done;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   sb_q[$];
    word_arr_t    model;
    vec_t         vecs[4];

    prog_loader #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .addr       (addr),
        .instruction(instruction),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    // Asynchronous pulse between edges; outputs must react without a clock
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk_idle("rst_out");
        chk("rst_instr", 32'(instruction), 32'd0);
        #1 rst = 1'b0;
        model = '{default: 8'h00};
    endtask

    task automatic send_bit(input logic b, input bit gapped);
        if (gapped) begin
            ser_valid = 1'b0;
            ser_in    = ~b;
            tick();
            chk("busy_in_gap", 32'(busy), 32'd1);
        end
        ser_valid = 1'b1;
        ser_in    = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic load_words(input word_arr_t w, input bit gapped, input int nwords);
        load_en = 1'b1;
        tick();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        for (int wi = 0; wi < nwords; wi++) begin
            model[wi] = w[wi];
            for (int b = 7; b >= 0; b--) begin
                if (nwords == Depth && wi == Depth - 1 && b == 0)
                    chk("done_before_last", 32'(done), 32'd0);
                send_bit(w[wi][b], gapped);
            end
        end
        if (nwords == Depth) begin
            chk("end_busy", 32'(busy), 32'd0);
            load_en = 1'b0;
        end
    endtask

    task automatic expect_mem();
        for (int a = 0; a < Depth; a++) sb_q.push_back(model[a]);
    endtask

    task automatic expect_zero();
        for (int a = 0; a < Depth; a++) sb_q.push_back(8'h00);
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < Depth; a++) begin
            addr = N'(a);
            #1;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s_sb_empty: got empty queue, expected entry", tag);
            end else begin
                chk(tag, 32'(instruction), 32'(sb_q.pop_front()));
            end
        end
    endtask

    initial begin
        word_arr_t w;

        vecs[0] = '{"full_load",   '{8'h12, 8'h34, 8'h56, 8'h78}, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"gapped_load", '{8'h12, 8'h34, 8'h56, 8'h78}, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"reload_ff",   '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"mixed_load",  '{8'h00, 8'hFF, 8'hA5, 8'h5A}, 1'b0, 1'b1, 1'b0};

        // Reset state and idle hold
        tick();
        do_reset();
        tick();
        tick();
        chk_idle("post_reset");

        // Table-driven full loads, each starting from the previous state
        for (int i = 0; i < 4; i++) begin
            load_words(vecs[i].w, vecs[i].gapped, Depth);
            chk({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].exp_done));
            chk({vecs[i].name, "_hold"}, 32'(cpu_hold), 32'(vecs[i].exp_hold));
            expect_mem();
            readback(vecs[i].name);
        end

        // Serial inputs are ignored while running
        for (int i = 0; i < 24; i++) begin
            ser_in    = 1'($urandom);
            ser_valid = 1'($urandom);
            tick();
            chk("run_ign_done", 32'(done), 32'd1);
            chk("run_ign_busy", 32'(busy), 32'd0);
        end
        ser_valid = 1'b0;
        expect_mem();
        readback("run_ign_mem");

        // Serial inputs are ignored while idle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ser_in    = 1'($urandom);
            ser_valid = 1'($urandom);
            tick();
            chk("idle_ign_busy", 32'(busy), 32'd0);
            chk("idle_ign_instr", 32'(instruction), 32'd0);
        end

        // Abort after 13 bits: one full word plus 5 bits of the next
        load_en = 1'b1;
        tick();
        w[0] = 8'hA5;
        w[1] = 8'h3C;
        for (int b = 7; b >= 0; b--) send_bit(w[0][b], 1'b0);
        for (int b = 7; b >= 3; b--) send_bit(w[1][b], 1'b0);
        load_en   = 1'b0;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        tick();
        ser_valid = 1'b0;
        chk_idle("abort");
        expect_zero();
        readback("abort_instr");
        load_words('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, Depth);
        chk("after_abort_done", 32'(done), 32'd1);
        expect_mem();
        readback("after_abort_mem");

        // Async reset in the middle of the 20th bit
        do_reset();
        load_en = 1'b1;
        tick();
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 19; k++) send_bit(w[k / 8][7 - (k % 8)], 1'b0);
        ser_in    = w[2][7 - 3];
        ser_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_instr", 32'(instruction), 32'd0);
        #1 rst = 1'b0;
        load_en   = 1'b0;
        ser_valid = 1'b0;
        model     = '{default: 8'h00};
        tick();
        tick();
        chk_idle("after_rst");
        expect_zero();
        readback("after_rst_instr");

        // A partial load must not release the core
        load_words('{8'hC1, 8'hC2, 8'hC3, 8'h00}, 1'b0, 3);
        chk("partial_done", 32'(done), 32'd0);
        chk("partial_busy", 32'(busy), 32'd1);
        load_en = 1'b0;
        tick();
        chk_idle("partial_abort");
        load_words('{8'h9A, 8'hBC, 8'hDE, 8'hF0}, 1'b0, Depth);
        chk("final_done", 32'(done), 32'd1);
        expect_mem();
        readback("final_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
